unidade_controle_ula: RTL and testbench

- Multi-cycle control FSM for the 16-bit ALU/PC datapath.
- Accepts one 16-bit instruction per fetch handshake and decodes it.
- Drives the ALU operation select (codop) and the PC source select (fontecp), sequences register-file writeback, and starts and waits on the external multiplier whose low/high results the ALU forwards.
- Sits between instruction memory, register file, ALU and multiplier.

---
 rtl/unidade_controle_ula.sv | 107 ++++++++++
 tb/tb_unidade_controle_ula.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_ula.sv
// unidade_controle_ula: multi-cycle control FSM for the 16-bit ALU/PC datapath with external multiplier.
// Define CONTADOR_INSTR_EN to add the retired-instruction counter output instr_concluidas.
module unidade_controle_ula #(
  parameter int unsigned LIMITE_MULT = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instr_req,
  input  logic        instr_valido,
  input  logic [15:0] instr,
  output logic [3:0]  codop,
  output logic [1:0]  fontecp,
  output logic        reg_escrita,
  output logic [3:0]  reg_dest,
  output logic        mult_inicio,
  input  logic        mult_pronto,
  output logic        parado,
  output logic        erro_mult
`ifdef CONTADOR_INSTR_EN
  , output logic [31:0] instr_concluidas
`endif
);
  typedef enum logic [3:0] {
    BUSCA, DECODIFICA, EXECUTA, ESCREVE, SALTO, MULT_INICIO, MULT_ESPERA,
    MULT_BAIXO, MULT_ESC_BAIXO, MULT_ALTO, MULT_ESC_ALTO, PARADO
  } estado_t;
  estado_t st, nxt;
  logic [15:0] ir, ir_n;
  logic [7:0] cnt, cnt_n;
  logic erro_n;
  logic [3:0] op, op_n, rd_n;
  assign op = ir[15:12];
  assign op_n = ir_n[15:12];
  assign rd_n = ir_n[11:8];
  always_comb begin
    nxt = st;
    ir_n = ir;
    cnt_n = cnt;
    erro_n = erro_mult;
    case (st)
      BUSCA: if (instr_req && instr_valido) begin
        ir_n = instr;
        nxt = DECODIFICA;
      end
      DECODIFICA: nxt = op <= 4'hA ? EXECUTA :
                        (op == 4'hB || op == 4'hC) ? SALTO :
                        op == 4'hD ? MULT_INICIO :
                        op == 4'hE ? PARADO : BUSCA;
      EXECUTA: nxt = ESCREVE;
      MULT_INICIO: begin
        cnt_n = 8'd0;
        nxt = MULT_ESPERA;
      end
      MULT_ESPERA: if (mult_pronto) nxt = MULT_BAIXO;
      else begin
        cnt_n = cnt + 8'd1;
        if (cnt_n == 8'(LIMITE_MULT)) begin
          erro_n = 1'b1;
          nxt = PARADO;
        end
      end
      MULT_BAIXO: nxt = MULT_ESC_BAIXO;
      MULT_ESC_BAIXO: nxt = MULT_ALTO;
      MULT_ALTO: nxt = MULT_ESC_ALTO;
      ESCREVE, SALTO, MULT_ESC_ALTO: nxt = BUSCA;
      default: nxt = PARADO;
    endcase
  end
  // Outputs are registered from the state being entered, so each state's outputs are valid throughout it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= BUSCA;
      ir <= '0;
      cnt <= '0;
      instr_req <= 1'b0;
      codop <= 4'b1111;
      fontecp <= 2'b10;
      reg_escrita <= 1'b0;
      reg_dest <= 4'd0;
      mult_inicio <= 1'b0;
      parado <= 1'b0;
      erro_mult <= 1'b0;
`ifdef CONTADOR_INSTR_EN
      instr_concluidas <= '0;
`endif
    end else begin
      st <= nxt;
      ir <= ir_n;
      cnt <= cnt_n;
      instr_req <= nxt == BUSCA;
      codop <= (nxt inside {EXECUTA, ESCREVE, SALTO}) ? op_n :
               (nxt inside {MULT_BAIXO, MULT_ESC_BAIXO}) ? 4'b1101 :
               (nxt inside {MULT_ALTO, MULT_ESC_ALTO}) ? 4'b1110 : 4'b1111;
      fontecp <= (nxt inside {ESCREVE, MULT_ESC_ALTO} || (nxt == DECODIFICA && op_n == 4'hF)) ? 2'b00 :
                 nxt == SALTO ? 2'b01 : 2'b10;
      reg_escrita <= nxt inside {ESCREVE, MULT_ESC_BAIXO, MULT_ESC_ALTO};
      reg_dest <= nxt == MULT_ESC_ALTO ? rd_n + 4'd1 :
                  (nxt inside {ESCREVE, MULT_ESC_BAIXO}) ? rd_n : 4'd0;
      mult_inicio <= nxt == MULT_INICIO;
      parado <= nxt == PARADO;
      erro_mult <= erro_n;
`ifdef CONTADOR_INSTR_EN
      instr_concluidas <= instr_concluidas + 32'(fontecp != 2'b10);
`endif
    end
  end
endmodule

// File: tb/tb_unidade_controle_ula.sv
// tb_unidade_controle_ula: randomized instruction stream checked cycle by cycle against a per-instruction expected-output model.
module tb_unidade_controle_ula;
  localparam int L = 32;
  logic clock = 1'b0, reset = 1'b1, instr_valido = 1'b0, mult_pronto = 1'b0;
  logic [15:0] instr = '0;
  logic instr_req, reg_escrita, mult_inicio, parado, erro_mult;
  logic [3:0] codop, reg_dest;
  logic [1:0] fontecp;
`ifdef CONTADOR_INSTR_EN
  logic [31:0] instr_concluidas;
`endif
  unidade_controle_ula #(.LIMITE_MULT(L)) dut (
    .clock(clock), .reset(reset), .instr_req(instr_req), .instr_valido(instr_valido),
    .instr(instr), .codop(codop), .fontecp(fontecp), .reg_escrita(reg_escrita),
    .reg_dest(reg_dest), .mult_inicio(mult_inicio), .mult_pronto(mult_pronto),
    .parado(parado), .erro_mult(erro_mult)
`ifdef CONTADOR_INSTR_EN
    , .instr_concluidas(instr_concluidas)
`endif
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic req; logic [3:0] codop; logic [1:0] fcp; logic we; logic [3:0] rd;
    logic mi; logic par; logic err; logic pronto;
  } ent_t;
  ent_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit halted = 0, herr = 0;
  logic [31:0] exp_cnt = '0;
  function automatic ent_t idle();
    ent_t e;
    e = '0;
    e.codop = 4'hF;
    e.fcp = 2'b10;
    e.pronto = 1'($urandom);
    return e;
  endfunction
  function automatic ent_t dflt();
    ent_t e;
    e = idle();
    if (halted) begin
      e.par = 1'b1;
      e.err = herr;
    end else e.req = 1'b1;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask
  // Expected outputs for every cycle after accept; k = ESPERA cycle in which mult_pronto rises.
  task automatic push_instr(input logic [15:0] w, input int k);
    ent_t e;
    logic [3:0] op, rd;
    op = w[15:12];
    rd = w[11:8];
    e = idle();
    if (op == 4'hF) e.fcp = 2'b00;
    q.push_back(e);
    if (op <= 4'hA) begin
      e = idle(); e.codop = op; q.push_back(e);
      e = idle(); e.codop = op; e.we = 1; e.rd = rd; e.fcp = 2'b00; q.push_back(e);
    end else if (op == 4'hB || op == 4'hC) begin
      e = idle(); e.codop = op; e.fcp = 2'b01; q.push_back(e);
    end else if (op == 4'hD) begin
      e = idle(); e.mi = 1; q.push_back(e);
      for (int j = 1; j <= L && j <= k; j++) begin
        e = idle(); e.pronto = (j == k); q.push_back(e);
      end
      if (k > L) begin
        halted = 1; herr = 1;
      end else begin
        e = idle(); e.codop = 4'hD; q.push_back(e);
        e = idle(); e.codop = 4'hD; e.we = 1; e.rd = rd; q.push_back(e);
        e = idle(); e.codop = 4'hE; q.push_back(e);
        e = idle(); e.codop = 4'hE; e.we = 1; e.rd = rd + 4'd1; e.fcp = 2'b00; q.push_back(e);
      end
    end else if (op == 4'hE) halted = 1;
  endtask
  task automatic cycle(output bit rdy);
    ent_t e;
    bit busy;
    @(negedge clock);
    busy = q.size() != 0;
    e = busy ? q.pop_front() : dflt();
    chk("instr_req", 32'(instr_req), 32'(e.req));
    chk("codop", 32'(codop), 32'(e.codop));
    chk("fontecp", 32'(fontecp), 32'(e.fcp));
    chk("reg_escrita", 32'(reg_escrita), 32'(e.we));
    if (e.we) chk("reg_dest", 32'(reg_dest), 32'(e.rd));
    chk("mult_inicio", 32'(mult_inicio), 32'(e.mi));
    chk("parado", 32'(parado), 32'(e.par));
    chk("erro_mult", 32'(erro_mult), 32'(e.err));
`ifdef CONTADOR_INSTR_EN
    chk("instr_concluidas", instr_concluidas, exp_cnt);
`endif
    exp_cnt += 32'(e.fcp != 2'b10);
    mult_pronto = e.pronto;
    busy = busy || halted;
    instr_valido = busy ? 1'($urandom) : 1'b0;
    instr = 16'($urandom);
    rdy = !busy;
  endtask
  task automatic run(input int n);
    bit r;
    for (int i = 0; i < n; i++) cycle(r);
  endtask
  task automatic issue(input logic [15:0] w, input int k);
    bit r;
    for (int i = 0; i < 200; i++) begin
      cycle(r);
      if (r && $urandom_range(0, 3) != 0) begin
        instr_valido = 1'b1;
        instr = w;
        push_instr(w, k);
        return;
      end
    end
    chk("issue_timeout", 32'd0, 32'd1);
  endtask
  task automatic do_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_instr_req", 32'(instr_req), 32'd0);
    chk("rst_codop", 32'(codop), 32'hF);
    chk("rst_fontecp", 32'(fontecp), 32'd2);
    chk("rst_reg_escrita", 32'(reg_escrita), 32'd0);
    chk("rst_reg_dest", 32'(reg_dest), 32'd0);
    chk("rst_mult_inicio", 32'(mult_inicio), 32'd0);
    chk("rst_parado", 32'(parado), 32'd0);
    chk("rst_erro_mult", 32'(erro_mult), 32'd0);
    reset = 1'b0;
    instr_valido = 1'b0;
    q.delete();
    halted = 0; herr = 0; exp_cnt = '0;
  endtask
  initial begin
    bit r;
    @(negedge clock);
    do_reset();
    issue(16'h0312, 0);
    chk("pin_add_codop", 32'(q[1].codop), 32'h0);
    chk("pin_add_we", 32'(q[2].we), 32'd1);
    chk("pin_add_rd", 32'(q[2].rd), 32'd3);
    chk("pin_add_fcp", 32'(q[2].fcp), 32'd0);
    issue(16'hF000, 0);
    issue(16'hB000, 0);
    chk("pin_jmp_len", 32'(q.size()), 32'd2);
    chk("pin_jmp_fcp", 32'(q[1].fcp), 32'd1);
    issue(16'hDF00, 5);
    chk("pin_mul_lo_rd", 32'(q[8].rd), 32'd15);
    chk("pin_mul_lo_op", 32'(q[8].codop), 32'hD);
    chk("pin_mul_hi_rd", 32'(q[10].rd), 32'd0);
    chk("pin_mul_hi_op", 32'(q[10].codop), 32'hE);
    issue(16'hE000, 0);
    run(16);
`ifdef CONTADOR_INSTR_EN
    chk("count_four", instr_concluidas, 32'd4);
`endif
    do_reset();
    issue(16'hD200, L + 1);
    while (q.size() != 0) cycle(r);
    for (int i = 0; i < 4; i++) begin
      cycle(r);
      instr_valido = 1'b1;
      instr = 16'h0000;
    end
    run(2);
    chk("timeout_parado", 32'(parado), 32'd1);
    chk("timeout_erro", 32'(erro_mult), 32'd1);
    do_reset();
    issue(16'hD200, 100);
    run(10);
    do_reset();
    issue(16'h0312, 0);
    for (int n = 0; n < 300; n++) begin
      logic [15:0] w;
      int k;
      w = 16'($urandom);
      k = $urandom_range(0, 7) == 0 ? L + int'($urandom_range(0, 1)) : int'($urandom_range(1, 8));
      issue(w, k);
      if (halted) begin
        while (q.size() != 0) cycle(r);
        run(3);
        do_reset();
      end
    end
    run(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
